// File: rtl/uart_rx_oversampled.sv
// UART receiver: 2-FF synchronised serial input, mid-bit start qualification,
// LSB-first data sampling at bit centres, stop-bit check, valid/ready output
// with framing-error and overrun pulses. All frame timing advances on rx_en.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_m;
    logic                 rx_s;
    logic [1:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_tick;
    logic                 deliver;
    logic                 frame_bad;

    // Stop-bit sample point and its two outcomes
    assign stop_tick = rx_en && (state == S_STOP) && (tick_cnt == TICK_LAST);
    assign deliver   = stop_tick && rx_s;
    assign frame_bad = stop_tick && !rx_s;
    assign rx_busy   = (state != S_IDLE);

    // Two-stage synchroniser on the asynchronous serial line, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: start qualification, data shifting, stop-bit timing
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (rx_en) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        tick_cnt <= '0;
                        bit_idx  <= bit_idx + BW'(1);
                        if (bit_idx == BIT_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // Output stage: handshake, byte delivery, framing and overrun pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
